// File: rtl/prefetch_queue.sv
// x86 instruction prefetch queue: fetches code bytes ahead of the decoder and
// yields the byte-wide memory bus to CPU data cycles via request/grant.
module prefetch_queue #(
    parameter int unsigned DEPTH = 6,
    parameter int unsigned AW    = 20
) (
    input  logic          clock,
    input  logic          locked,
    input  logic          flush,
    input  logic [AW-1:0] flush_addr,
    output logic [7:0]    q_data,
    output logic          q_valid,
    input  logic          q_pop,
    output logic [3:0]    q_count,
    input  logic          bus_req,
    output logic          bus_grant,
    input  logic [AW-1:0] cpu_address,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [7:0]    cpu_dout,
    output logic [7:0]    cpu_din,
    output logic [AW-1:0] m_address,
    output logic          m_rd,
    output logic          m_wr,
    output logic [7:0]    m_dout,
    input  logic [7:0]    m_data_in
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 4;
    localparam logic [AW-1:0] RESET_FP = AW'(20'hFFFF0);

    typedef enum logic {
        OWN_PF,
        OWN_CPU
    } own_e;

    own_e          own_q, own_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] fp_q, fp_d;
    logic          pending_q, pending_d;

    logic          room;
    logic          issue;
    logic          grant;
    logic          wr_en;
    logic          pop_en;

    // Queue bookkeeping, fetch issue and ownership next-state
    always_comb begin
        own_d     = own_q;
        mem_d     = mem_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        fp_d      = fp_q;

        // An in-flight byte reserves its slot so the queue never overflows
        room      = (5'({1'b0, count_q}) + 5'(pending_q)) < 5'(DEPTH);
        grant     = locked & bus_req & ~pending_q;
        issue     = locked & ~flush & ~bus_req & room;
        wr_en     = pending_q & ~flush;
        pop_en    = q_pop & (count_q != '0) & ~flush;
        pending_d = issue;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            fp_d    = flush_addr;
        end else begin
            if (wr_en) begin
                mem_d[tail_q] = m_data_in;
                tail_d = (tail_q == PW'(DEPTH - 1)) ? '0 : tail_q + PW'(1);
            end
            if (pop_en) begin
                head_d = (head_q == PW'(DEPTH - 1)) ? '0 : head_q + PW'(1);
            end
            count_d = count_q + CW'(wr_en) - CW'(pop_en);
            if (issue) begin
                fp_d = fp_q + AW'(1);
            end
        end

        case (own_q)
            OWN_PF:  if (grant)    own_d = OWN_CPU;
            OWN_CPU: if (!bus_req) own_d = OWN_PF;
            default:               own_d = OWN_PF;
        endcase
    end

    // State register; reset drops any in-flight byte and restarts at the reset vector
    always_ff @(posedge clock) begin
        if (!locked) begin
            own_q     <= OWN_PF;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            fp_q      <= RESET_FP;
            pending_q <= 1'b0;
        end else begin
            own_q     <= own_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            fp_q      <= fp_d;
            pending_q <= pending_d;
        end
    end

    // Byte storage needs no reset: count gates every read
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    // Bus mux: the granted CPU drives the strobes, otherwise the prefetcher
    always_comb begin
        m_address = fp_q;
        m_rd      = issue;
        m_wr      = 1'b0;
        if (grant) begin
            m_address = cpu_address;
            m_rd      = cpu_rd;
            m_wr      = cpu_wr;
        end
    end

    assign bus_grant = grant;
    assign q_data    = mem_q[head_q];
    assign q_valid   = locked & (count_q != '0);
    assign q_count   = count_q;
    assign cpu_din   = m_data_in;
    assign m_dout    = cpu_dout;

endmodule
